// File: rtl/fib_seq_gen_if.sv
// Fibonacci sequence generator bus.
// Groups the request side (start, seeds, length, overflow policy), the term
// stream (out_data/out_valid/out_ready) and the status flags (busy, done,
// overflow). The clock and reset are not part of this bundle.
//   master : requester / consumer (drives start, seeds, length, wrap_mode, out_ready)
//   slave  : generator (drives out_data, out_valid, busy, done, overflow)
interface fib_seq_gen_if #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8
);
    logic             start;
    logic [WIDTH-1:0] seed0;
    logic [WIDTH-1:0] seed1;
    logic [LEN_W-1:0] length;
    logic             wrap_mode;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;
    logic             overflow;

    modport master (
        output start, seed0, seed1, length, wrap_mode, out_ready,
        input  out_data, out_valid, busy, done, overflow
    );

    modport slave (
        input  start, seed0, seed1, length, wrap_mode, out_ready,
        output out_data, out_valid, busy, done, overflow
    );
endinterface

// File: rtl/fib_seq_gen.sv
// Fibonacci sequence generator.
// On an accepted start it emits `length` terms beginning with seed0, seed1,
// each later term being the sum of the two before it. Each term is offered
// with a valid/ready handshake. On overflow, the policy captured at start
// either wraps the term modulo 2^WIDTH or saturates it to all-ones. Either
// way, a sticky overflow flag is set.
// Ports:
//   clk   - single clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - fib_seq_gen_if slave modport (request, term stream, status)
module fib_seq_gen #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    fib_seq_gen_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q,     state_d;
    logic [WIDTH-1:0] prev_q,      prev_d;
    logic [WIDTH-1:0] curr_q,      curr_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic             mode_q,      mode_d;
    logic             overflow_q,  overflow_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;

    logic [WIDTH:0]   next_s;
    logic             accept_s;

    // One extra bit so the carry out of the addition is visible.
    assign next_s   = {1'b0, prev_q} + {1'b0, curr_q};
    // The generator offers a term in every RUN cycle, so out_valid is implied here.
    assign accept_s = (state_q == ST_RUN) && bus.out_ready;

    // Next-state and datapath logic.
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        curr_d      = curr_q;
        remaining_d = remaining_q;
        mode_d      = mode_q;
        overflow_d  = overflow_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    prev_d      = bus.seed0;
                    curr_d      = bus.seed1;
                    remaining_d = bus.length;
                    mode_d      = bus.wrap_mode;
                    overflow_d  = 1'b0;
                    if (bus.length != LEN_W'(0)) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s) begin
                    prev_d      = curr_q;
                    remaining_d = remaining_q - LEN_W'(1);
                    if (next_s[WIDTH]) begin
                        overflow_d = 1'b1;
                        if (mode_q) begin
                            curr_d = next_s[WIDTH-1:0];
                        end else begin
                            curr_d = {WIDTH{1'b1}};
                        end
                    end else begin
                        curr_d = next_s[WIDTH-1:0];
                    end
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output flops are loaded from the upcoming state. This makes them
    // line up with state_q without any combinational decode at the ports.
    // out_data freezes on the last emitted term once RUN is left.
    always_comb begin
        out_valid_d = (state_d == ST_RUN);
        busy_d      = (state_d == ST_RUN);
        done_d      = (state_d == ST_DONE);
        if (state_d == ST_RUN) begin
            out_data_d = prev_d;
        end else begin
            out_data_d = out_data_q;
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            prev_q      <= {WIDTH{1'b0}};
            curr_q      <= {WIDTH{1'b0}};
            out_data_q  <= {WIDTH{1'b0}};
            remaining_q <= {LEN_W{1'b0}};
            mode_q      <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            curr_q      <= curr_d;
            out_data_q  <= out_data_d;
            remaining_q <= remaining_d;
            mode_q      <= mode_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Directed testbench for fib_seq_gen (WIDTH=8, LEN_W=8).
// Drives inputs 1 time unit after each rising edge and samples outputs at
// that same point. Expected values are hand-computed constants.
module tb_fib_seq_gen;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    logic [7:0] got [256];
    int         nterms;
    int         ndone;
    int         done_cyc;

    logic [7:0] fib14 [14] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8,
                               8'd13, 8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233};

    fib_seq_gen_if #(.WIDTH(8), .LEN_W(8)) bus ();

    fib_seq_gen #(.WIDTH(8), .LEN_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Starts a sequence, then collects accepted terms until done is seen.
    // bp=1 drives out_ready in the pattern 1,0,0,1,0,0,...
    // poke=1 pulses start with other seeds while the sequence is running.
    task automatic run(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] len,
                       input logic wr, input logic bp, input logic poke);
        logic       stalled;
        logic [7:0] held;
        nterms   = 0;
        ndone    = 0;
        done_cyc = -1;
        stalled  = 1'b0;
        held     = 8'd0;
        bus.seed0     = s0;
        bus.seed1     = s1;
        bus.length    = len;
        bus.wrap_mode = wr;
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 400 && ndone == 0; cyc++) begin
            bus.out_ready = bp ? ((cyc % 3) == 0) : 1'b1;
            if (poke && cyc == 2) begin
                bus.start = 1'b1;
                bus.seed0 = 8'd50;
                bus.seed1 = 8'd50;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                ndone++;
                done_cyc = cyc;
            end
            if (bus.out_valid) begin
                if (stalled) chk("stall_hold", 32'(bus.out_data), 32'(held));
                if (bus.out_ready) begin
                    if (nterms < 256) got[nterms] = bus.out_data;
                    nterms++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = bus.out_data;
                end
            end
            tick();
        end
        bus.start = 1'b0;
        chk("done_seen_once", 32'(ndone), 32'd1);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.seed0     = 8'd0;
        bus.seed1     = 8'd0;
        bus.length    = 8'd0;
        bus.wrap_mode = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        // Reset state
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy",  32'(bus.busy),      32'd0);
        chk("rst_done",  32'(bus.done),      32'd0);
        chk("rst_ovf",   32'(bus.overflow),  32'd0);
        chk("rst_data",  32'(bus.out_data),  32'd0);
        rst_n = 1'b1;

        // Basic run: 14 terms, overflow on the 13th accept
        bus.seed0     = 8'd0;
        bus.seed1     = 8'd1;
        bus.length    = 8'd14;
        bus.wrap_mode = 1'b1;
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            chk("basic_valid", 32'(bus.out_valid), 32'd1);
            chk("basic_busy",  32'(bus.busy),      32'd1);
            chk("basic_data",  32'(bus.out_data),  32'(fib14[i]));
            if (i == 12) chk("basic_ovf_pre",  32'(bus.overflow), 32'd0);
            if (i == 13) chk("basic_ovf_post", 32'(bus.overflow), 32'd1);
            tick();
        end
        chk("basic_done",      32'(bus.done),      32'd1);
        chk("basic_end_valid", 32'(bus.out_valid), 32'd0);
        chk("basic_end_busy",  32'(bus.busy),      32'd0);
        chk("basic_end_hold",  32'(bus.out_data),  32'd233);
        tick();
        chk("basic_done_once", 32'(bus.done),      32'd0);
        chk("basic_idle_busy", 32'(bus.busy),      32'd0);
        chk("basic_ovf_keep",  32'(bus.overflow),  32'd1);

        // Wrap: terms 15,16 = 121,98
        run(8'd0, 8'd1, 8'd16, 1'b1, 1'b0, 1'b0);
        chk("wrap_n",   32'(nterms),       32'd16);
        chk("wrap_t15", 32'(got[14]),      32'd121);
        chk("wrap_t16", 32'(got[15]),      32'd98);
        chk("wrap_ovf", 32'(bus.overflow), 32'd1);

        // Saturate: terms 14,15,16 = 233,255,255
        run(8'd0, 8'd1, 8'd16, 1'b0, 1'b0, 1'b0);
        chk("sat_n",   32'(nterms),       32'd16);
        chk("sat_t14", 32'(got[13]),      32'd233);
        chk("sat_t15", 32'(got[14]),      32'd255);
        chk("sat_t16", 32'(got[15]),      32'd255);
        chk("sat_ovf", 32'(bus.overflow), 32'd1);

        // Backpressure: 0,1,1,2,3 with stalls
        run(8'd0, 8'd1, 8'd5, 1'b1, 1'b1, 1'b0);
        chk("bp_n",  32'(nterms), 32'd5);
        chk("bp_t1", 32'(got[0]), 32'd0);
        chk("bp_t2", 32'(got[1]), 32'd1);
        chk("bp_t3", 32'(got[2]), 32'd1);
        chk("bp_t4", 32'(got[3]), 32'd2);
        chk("bp_t5", 32'(got[4]), 32'd3);

        // Zero length: no terms, done right after the start edge, overflow cleared
        run(8'd7, 8'd9, 8'd0, 1'b1, 1'b0, 1'b0);
        chk("zero_n",    32'(nterms),       32'd0);
        chk("zero_dcyc", 32'(done_cyc),     32'd0);
        chk("zero_ovf",  32'(bus.overflow), 32'd0);
        chk("zero_hold", 32'(bus.out_data), 32'd3);

        // Start pulses during RUN are ignored
        run(8'd1, 8'd1, 8'd6, 1'b1, 1'b0, 1'b1);
        chk("poke_n",  32'(nterms), 32'd6);
        chk("poke_t3", 32'(got[2]), 32'd2);
        chk("poke_t6", 32'(got[5]), 32'd8);

        // Maximum length: counter must not wrap
        run(8'd0, 8'd0, 8'd255, 1'b1, 1'b0, 1'b0);
        chk("max_n",   32'(nterms),       32'd255);
        chk("max_ovf", 32'(bus.overflow), 32'd0);

        // Reset mid-run after 4 accepted terms
        bus.seed0     = 8'd0;
        bus.seed1     = 8'd1;
        bus.length    = 8'd10;
        bus.wrap_mode = 1'b1;
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("mid_pre_data", 32'(bus.out_data), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_busy",  32'(bus.busy),      32'd0);
        chk("mid_rst_data",  32'(bus.out_data),  32'd0);
        chk("mid_rst_done",  32'(bus.done),      32'd0);
        #2;
        rst_n = 1'b1;
        run(8'd2, 8'd3, 8'd4, 1'b0, 1'b0, 1'b0);
        chk("post_n",   32'(nterms),       32'd4);
        chk("post_t1",  32'(got[0]),       32'd2);
        chk("post_t2",  32'(got[1]),       32'd3);
        chk("post_t3",  32'(got[2]),       32'd5);
        chk("post_t4",  32'(got[3]),       32'd8);
        chk("post_ovf", 32'(bus.overflow), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
